// File: rtl/mcdt_pkg.sv
// Shared types and BCD/seconds conversion helpers for the multi-channel countdown timer.
package mcdt_pkg;

    localparam int unsigned SEC_W = 19;
    localparam logic [SEC_W-1:0] MAX_SECONDS = 19'd359999;

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    function automatic logic bcd_valid(input logic [7:0] h, input logic [7:0] m,
                                       input logic [7:0] s);
        return (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
               (m[7:4] <= 4'd5) && (m[3:0] <= 4'd9) &&
               (s[7:4] <= 4'd5) && (s[3:0] <= 4'd9);
    endfunction

    function automatic logic [SEC_W-1:0] bcd_to_secs(input logic [7:0] h, input logic [7:0] m,
                                                     input logic [7:0] s);
        int unsigned hh, mm, ss;
        hh = 32'(h[7:4]) * 10 + 32'(h[3:0]);
        mm = 32'(m[7:4]) * 10 + 32'(m[3:0]);
        ss = 32'(s[7:4]) * 10 + 32'(s[3:0]);
        return SEC_W'(hh * 3600 + mm * 60 + ss);
    endfunction

    // Packed {hour, minute, second}, two BCD digits each.
    function automatic logic [23:0] secs_to_bcd(input logic [SEC_W-1:0] secs);
        int unsigned t, hh, mm, ss;
        t  = 32'(secs);
        hh = t / 3600;
        mm = (t % 3600) / 60;
        ss = t % 60;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

endpackage

// File: rtl/multi_countdown_timer_if.sv
// Command, preset and status bundle of the multi-channel countdown timer.
interface multi_countdown_timer_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
    logic [CW-1:0]     ch_sel;
    logic              load;
    logic              start;
    logic              pause;
    logic              ack;
    logic [7:0]        hour_bcd_in;
    logic [7:0]        minute_bcd_in;
    logic [7:0]        second_bcd_in;
    logic [7:0]        hour_bcd_out;
    logic [7:0]        minute_bcd_out;
    logic [7:0]        second_bcd_out;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] ring;
    logic              any_ring;
    logic              load_err;

    modport master (
        output ch_sel, load, start, pause, ack, hour_bcd_in, minute_bcd_in, second_bcd_in,
        input  hour_bcd_out, minute_bcd_out, second_bcd_out, running, ring, any_ring, load_err
    );

    modport slave (
        input  ch_sel, load, start, pause, ack, hour_bcd_in, minute_bcd_in, second_bcd_in,
        output hour_bcd_out, minute_bcd_out, second_bcd_out, running, ring, any_ring, load_err
    );
endinterface

// File: rtl/mcdt_channel.sv
// One countdown channel: IDLE/RUN/PAUSE/DONE with sub-second prescaler and sticky ring.
// MULTI_COUNTDOWN_TIMER_AUTO_RELOAD_EN adds a preset register and reload-on-expiry.
module mcdt_channel
    import mcdt_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [SEC_W-1:0] load_secs_i,
    input  logic             start_i,
    input  logic             pause_i,
    input  logic             ack_i,
    output logic [SEC_W-1:0] remaining_o,
    output logic             running_o,
    output logic             ring_o
);

    localparam int unsigned SubW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SubW-1:0] SubLast = SubW'(TICKS_PER_SEC - 1);

    state_e           state_q, state_d;
    logic [SEC_W-1:0] rem_q, rem_d;
    logic [SubW-1:0]  sub_q, sub_d;
    logic             ring_q, ring_d;

`ifdef MULTI_COUNTDOWN_TIMER_AUTO_RELOAD_EN
    logic [SEC_W-1:0] preset_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      preset_q <= '0;
        else if (load_i) preset_q <= load_secs_i;
    end
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sub_d   = sub_q;
        ring_d  = ring_q;
        if (load_i) begin
            state_d = StIdle;
            rem_d   = load_secs_i;
            sub_d   = '0;
            ring_d  = 1'b0;
        end else begin
            // Ack clears first so a same-edge expiry below wins.
            if (ack_i) ring_d = 1'b0;
            unique case (state_q)
                StIdle, StPause: begin
                    if (start_i) begin
                        if (rem_q == '0) begin
                            state_d = StDone;
                            ring_d  = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    if (pause_i) begin
                        state_d = StPause;
                    end else if (sub_q == SubLast) begin
                        sub_d = '0;
                        if (rem_q == SEC_W'(1)) begin
                            ring_d = 1'b1;
`ifdef MULTI_COUNTDOWN_TIMER_AUTO_RELOAD_EN
                            rem_d = preset_q;
                            if (preset_q == '0) state_d = StDone;
`else
                            rem_d   = '0;
                            state_d = StDone;
`endif
                        end else begin
                            rem_d = rem_q - 1'b1;
                        end
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                StDone: begin
                    if (ack_i) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            sub_q   <= '0;
            ring_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sub_q   <= sub_d;
            ring_q  <= ring_d;
        end
    end

    assign remaining_o = rem_q;
    assign running_o   = (state_q == StRun);
    assign ring_o      = ring_q;

endmodule

// File: rtl/multi_countdown_timer.sv
// Multi-channel countdown timer: command decode, channel array, registered BCD display.
// Optional MULTI_COUNTDOWN_TIMER_AUTO_RELOAD_EN makes channels reload their preset on expiry.
module multi_countdown_timer
    import mcdt_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned CW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input logic                     clk,
    input logic                     rst_n,
    multi_countdown_timer_if.slave  bus
);

    logic             load_ok;
    logic [SEC_W-1:0] load_secs;
    logic [SEC_W-1:0] rem_arr [NUM_CH];
    logic [NUM_CH-1:0] running_v;
    logic [NUM_CH-1:0] ring_v;
    logic [SEC_W-1:0] sel_secs;
    logic [SEC_W-1:0] disp_secs_q;
    logic [23:0]      disp_bcd_q;
    logic             load_err_q;

    assign load_ok   = bcd_valid(bus.hour_bcd_in, bus.minute_bcd_in, bus.second_bcd_in);
    assign load_secs = bcd_to_secs(bus.hour_bcd_in, bus.minute_bcd_in, bus.second_bcd_in);

    // A load (accepted or not) consumes the cycle for the addressed channel.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic sel;
        assign sel = (bus.ch_sel == CW'(ch));

        mcdt_channel #(
            .TICKS_PER_SEC(TICKS_PER_SEC)
        ) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (sel & bus.load & load_ok),
            .load_secs_i(load_secs),
            .start_i    (sel & bus.start & ~bus.load),
            .pause_i    (sel & bus.pause & ~bus.load & ~bus.start),
            .ack_i      (sel & bus.ack & ~bus.load),
            .remaining_o(rem_arr[ch]),
            .running_o  (running_v[ch]),
            .ring_o     (ring_v[ch])
        );
    end

    always_comb begin
        sel_secs = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_sel == CW'(i)) sel_secs = rem_arr[i];
        end
    end

    // Two-stage display: select, then convert to BCD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_secs_q <= '0;
            disp_bcd_q  <= '0;
            load_err_q  <= 1'b0;
        end else begin
            disp_secs_q <= sel_secs;
            disp_bcd_q  <= secs_to_bcd(disp_secs_q);
            load_err_q  <= bus.load & ~load_ok;
        end
    end

    assign bus.hour_bcd_out   = disp_bcd_q[23:16];
    assign bus.minute_bcd_out = disp_bcd_q[15:8];
    assign bus.second_bcd_out = disp_bcd_q[7:0];
    assign bus.running        = running_v;
    assign bus.ring           = ring_v;
    assign bus.any_ring       = |ring_v;
    assign bus.load_err       = load_err_q;

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Directed self-checking bench for multi_countdown_timer (NUM_CH = 4, TICKS_PER_SEC = 4).
// Define MULTI_COUNTDOWN_TIMER_AUTO_RELOAD_EN to exercise the auto-reload build.
module tb_multi_countdown_timer;

    logic        clk;
    logic        rst_n;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    multi_countdown_timer_if #(.NUM_CH(4), .CW(2)) bus ();

    multi_countdown_timer #(
        .NUM_CH       (4),
        .TICKS_PER_SEC(4),
        .CW           (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] disp();
        return {8'h00, bus.hour_bcd_out, bus.minute_bcd_out, bus.second_bcd_out};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one command for one cycle; returns at the negedge after the sampling posedge.
    task automatic cmd(input logic [1:0] ch, input logic l, input logic st, input logic p,
                       input logic a, input logic [23:0] t);
        bus.ch_sel = ch;
        bus.load   = l;
        bus.start  = st;
        bus.pause  = p;
        bus.ack    = a;
        {bus.hour_bcd_in, bus.minute_bcd_in, bus.second_bcd_in} = t;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.ack   = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b1;
        bus.ch_sel = '0;
        bus.load   = 1'b0;
        bus.start  = 1'b0;
        bus.pause  = 1'b0;
        bus.ack    = 1'b0;
        {bus.hour_bcd_in, bus.minute_bcd_in, bus.second_bcd_in} = 24'h0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_running", 32'(bus.running), 32'h0);
        check("rst_ring", 32'(bus.ring), 32'h0);
        check("rst_any_ring", 32'(bus.any_ring), 32'h0);
        check("rst_load_err", 32'(bus.load_err), 32'h0);
        check("rst_disp", disp(), 32'h000000);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("idle_running", 32'(bus.running), 32'h0);

        // Valid load on ch1, then two rejected loads
        cmd(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000003);
        tick(2);
        check("load_disp", disp(), 32'h000003);
        check("load_no_err", 32'(bus.load_err), 32'h0);
        cmd(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h006000);
        check("err_min_pulse", 32'(bus.load_err), 32'h1);
        tick(1);
        check("err_min_clear", 32'(bus.load_err), 32'h0);
        check("err_min_disp", disp(), 32'h000003);
        cmd(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h00001A);
        check("err_sec_pulse", 32'(bus.load_err), 32'h1);
        tick(1);
        check("err_sec_clear", 32'(bus.load_err), 32'h0);
        check("err_sec_disp", disp(), 32'h000003);
        check("err_running", 32'(bus.running), 32'h0);

`ifndef MULTI_COUNTDOWN_TIMER_AUTO_RELOAD_EN
        // ch1: 3 s countdown, ring 12 cycles after RUN entry
        cmd(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        check("c1_running", 32'(bus.running), 32'h2);
        tick(6);
        check("c1_disp2", disp(), 32'h000002);
        tick(4);
        check("c1_disp1", disp(), 32'h000001);
        tick(1);
        check("c1_ring_early", 32'(bus.ring), 32'h0);
        tick(1);
        check("c1_ring", 32'(bus.ring), 32'h2);
        check("c1_done_running", 32'(bus.running), 32'h0);
        check("c1_any_ring", 32'(bus.any_ring), 32'h1);
        tick(2);
        check("c1_disp0", disp(), 32'h000000);
        cmd(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        check("c1_ack_ring", 32'(bus.ring), 32'h0);
        check("c1_ack_any", 32'(bus.any_ring), 32'h0);

        // ch0: 60 s with a 20-cycle pause after 8 RUN cycles
        cmd(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000100);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        check("c0_running", 32'(bus.running), 32'h1);
        tick(8);
        cmd(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
        check("c0_paused", 32'(bus.running), 32'h0);
        tick(20);
        check("c0_frozen", disp(), 32'h000058);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        check("c0_resumed", 32'(bus.running), 32'h1);
        tick(231);
        check("c0_ring_early", 32'(bus.ring), 32'h0);
        tick(1);
        check("c0_ring", 32'(bus.ring), 32'h1);
        check("c0_done", 32'(bus.running), 32'h0);
        cmd(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        check("c0_ack", 32'(bus.ring), 32'h0);

        // ch2/ch3 expire on the same edge that carries an ack to ch2
        cmd(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000001);
        cmd(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000002);
        cmd(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        tick(3);
        cmd(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        check("c23_running", 32'(bus.running), 32'hC);
        tick(3);
        cmd(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        check("c23_ring_both", 32'(bus.ring), 32'hC);
        cmd(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        check("c23_ack2_ring", 32'(bus.ring), 32'h8);
        check("c23_ack2_any", 32'(bus.any_ring), 32'h1);
        cmd(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        check("c23_ack3_ring", 32'(bus.ring), 32'h0);
`else
        // ch0: 2 s preset reloads on expiry and keeps running
        cmd(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000002);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        check("ar_running", 32'(bus.running), 32'h1);
        tick(7);
        check("ar_ring_early", 32'(bus.ring), 32'h0);
        tick(1);
        check("ar_ring", 32'(bus.ring), 32'h1);
        check("ar_still_running", 32'(bus.running), 32'h1);
        tick(2);
        check("ar_disp_reload", disp(), 32'h000002);
        tick(4);
        check("ar_disp1", disp(), 32'h000001);
        cmd(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        check("ar_ack", 32'(bus.ring), 32'h0);
        check("ar_running_after_ack", 32'(bus.running), 32'h1);
`endif

        // Asynchronous reset in the middle of a count
        cmd(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000003);
        cmd(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
        tick(6);
        check("mr_disp2", disp(), 32'h000002);
        #2 rst_n = 1'b0;
        #1;
        check("mr_running", 32'(bus.running), 32'h0);
        check("mr_ring", 32'(bus.ring), 32'h0);
        check("mr_any_ring", 32'(bus.any_ring), 32'h0);
        check("mr_disp", disp(), 32'h000000);
        check("mr_load_err", 32'(bus.load_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(20);
        check("mr_no_ring", 32'(bus.ring), 32'h0);
        check("mr_idle", 32'(bus.running), 32'h0);
        check("mr_disp_after", disp(), 32'h000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_countdown_timer.md
MULTI_COUNTDOWN_TIMER -- requirements
Module: multi_countdown_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent countdown channels, range 1..16.
REQ-002 Parameter TICKS_PER_SEC, default 1000: clk cycles per counted second.
REQ-003 Parameter CW, default $clog2(NUM_CH) (minimum 1): channel-select width.
REQ-004 clk  in  1  clock (1 kHz nominal).
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ch_sel  in  CW  channel addressed by load/start/pause/ack and shown on the display.
REQ-007 load, start, pause, ack  in  1 each  single-cycle command strobes, applied to ch_sel.
REQ-008 hour_bcd_in, minute_bcd_in, second_bcd_in  in  8 each  two-digit BCD preset value.
REQ-009 hour_bcd_out, minute_bcd_out, second_bcd_out  out  8 each  BCD remaining time of channel ch_sel.
REQ-010 running  out  NUM_CH  per channel: 1 while in RUN.
REQ-011 ring  out  NUM_CH  per channel: sticky expiry flag.
REQ-012 any_ring  out  1  OR of ring.
REQ-013 load_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-014 Each channel SHALL hold remaining time as binary seconds (19 bits, max 99:59:59 = 359999) plus a sub-second counter of $clog2(TICKS_PER_SEC) bits.
REQ-015 Each channel SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-016 Load SHALL convert BCD to seconds, clear the sub-second counter, clear ring, and enter IDLE from any state at the next edge.
REQ-017 Load with any digit >9, minutes >59 or seconds >59 SHALL be rejected: channel unchanged, load_err pulses the next cycle.
REQ-018 Start in IDLE or PAUSE SHALL enter RUN; start in RUN or DONE SHALL be ignored.
REQ-019 Start with remaining = 0 SHALL enter DONE and set ring at the next edge.
REQ-020 Pause in RUN SHALL enter PAUSE, freezing remaining and the sub-second counter; pause in any other state SHALL be ignored.
REQ-021 In RUN, the sub-second counter SHALL count 0..TICKS_PER_SEC-1; at wrap, remaining SHALL decrement by 1.
REQ-022 When remaining decrements to 0, the channel SHALL enter DONE and set ring on the same edge.
REQ-023 Ack SHALL clear ring of ch_sel; DONE then SHALL enter IDLE with remaining = 0.
REQ-024 Same-cycle priority SHALL be: load > start > pause; expiry set > ack clear.
REQ-025 Commands addressed to one channel SHALL NOT affect any other channel; all channels SHALL count concurrently.
REQ-026 Display outputs SHALL be registered, showing ch_sel's remaining time two cycles after the load or ch_sel change.
REQ-027 Hour output SHALL be 00..99; all out-of-range states are unreachable.

Reset
REQ-028 On rst_n low, all channels SHALL enter IDLE with remaining = 0 and sub-second = 0; all outputs SHALL be 0.
REQ-029 Reset asserted mid-count SHALL abort immediately, with no ring generated.

Configuration
REQ-030 With MULTI_COUNTDOWN_TIMER_AUTO_RELOAD_EN defined, each channel SHALL retain its last loaded preset; on expiry it SHALL set ring, reload the preset and stay in RUN (DONE entered only when preset = 0).
REQ-031 Without MULTI_COUNTDOWN_TIMER_AUTO_RELOAD_EN, expiry SHALL enter DONE per REQ-022, and no preset storage SHALL be synthesised.

Structure
REQ-032 A shared package mcdt_pkg SHALL hold: the state enum, constant MAX_SECONDS = 359999, the seconds width of 19, and BCD-to-seconds / seconds-to-BCD functions.
REQ-033 Per-channel logic SHALL be one sub-module mcdt_channel, instantiated NUM_CH times; the top SHALL hold command decode, the display mux and the conversion register.

Verification (TICKS_PER_SEC = 4, NUM_CH = 4)
REQ-034 Load ch1 with 00:00:03, then start -> running[1] = 1; ring[1] rises 12 cycles after RUN entry; display reads 00:00:02, 00:00:01, 00:00:00 in sequence.
REQ-035 Load ch0 with 00:01:00, start, pause after 8 cycles, hold 20 cycles, then start -> display frozen at 00:00:58 during pause; ring[0] rises at 240 RUN cycles in total.
REQ-036 Load with minute_bcd_in = 8'h60 or second_bcd_in = 8'h1A -> load_err pulses once; channel state and display are unchanged.
REQ-037 Ch2 and ch3 expire on the same cycle while ack is issued to ch2 on that cycle -> ring[2] = 1 and ring[3] = 1; a later ack to ch2 clears only ring[2]; any_ring stays 1.
REQ-038 rst_n pulsed low mid-count on ch0 at 00:00:02 -> all outputs are 0 asynchronously; no ring after release.
REQ-039 With AUTO_RELOAD_EN defined and preset 00:00:02 -> ring[0] sets at 8 cycles; the display shows 00:00:02 again and counting continues.
